// File: rtl/mips_bus_pkg.sv
// Shared definitions for the SRAM-like bus arbiter: FSM state encoding and
// bus transfer size codes.
package mips_bus_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_ADDR = 3'd1,
    I_WAIT = 3'd2,
    D_ADDR = 3'd3,
    D_WAIT = 3'd4
  } arb_state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/sram_like_arbiter_if.sv
// Signal bundle around the arbiter: instruction master, data master and the
// shared SRAM-like bus. "slave" is the arbiter's view, "master" the environment's.
interface sram_like_arbiter_if;

  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic [31:0] data_rdata;
  logic        data_data_ok;

  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic [31:0] rdata;
  logic        data_ok;

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_rdata, inst_data_ok,
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_rdata, data_data_ok,
    output req, wr, size, addr, wdata,
    input  addr_ok, rdata, data_ok
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_rdata, inst_data_ok,
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_rdata, data_data_ok,
    input  req, wr, size, addr, wdata,
    output addr_ok, rdata, data_ok
  );

endinterface

// File: rtl/sram_like_arbiter.sv
// Two-master SRAM-like bus arbiter: instruction and data masters share one bus
// with a single outstanding transaction and data-first round-robin on contention.
module sram_like_arbiter
  import mips_bus_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  sram_like_arbiter_if.slave io
);

  arb_state_e  state_q, state_d;
  logic        last_data_q, last_data_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic grant_data;
  logic grant_inst;
  logic inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, req;

  // Data wins a tie unless it also won the previous grant.
  assign grant_data = resetn && io.data_req && (!io.inst_req || !last_data_q);
  assign grant_inst = resetn && io.inst_req && !grant_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      last_data_q <= 1'b0;
      wr_q        <= 1'b0;
      size_q      <= SIZE_B;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      last_data_q <= last_data_d;
      wr_q        <= wr_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_data_d  = last_data_q;
    wr_d         = wr_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    req          = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_data) begin
          data_addr_ok = 1'b1;
          last_data_d  = 1'b1;
          wr_d         = io.data_wr;
          size_d       = io.data_size;
          addr_d       = io.data_addr;
          wdata_d      = io.data_wdata;
          state_d      = D_ADDR;
        end else if (grant_inst) begin
          inst_addr_ok = 1'b1;
          last_data_d  = 1'b0;
          wr_d         = 1'b0;
          size_d       = SIZE_W;
          addr_d       = io.inst_addr;
          wdata_d      = 32'd0;
          state_d      = I_ADDR;
        end
      end
      I_ADDR: begin
        req = 1'b1;
        if (io.addr_ok) begin
          // A bus that completes in the accept cycle skips the wait state.
          inst_data_ok = io.data_ok;
          state_d      = io.data_ok ? IDLE : I_WAIT;
        end
      end
      I_WAIT: begin
        if (io.data_ok) begin
          inst_data_ok = 1'b1;
          state_d      = IDLE;
        end
      end
      D_ADDR: begin
        req = 1'b1;
        if (io.addr_ok) begin
          data_data_ok = io.data_ok;
          state_d      = io.data_ok ? IDLE : D_WAIT;
        end
      end
      D_WAIT: begin
        if (io.data_ok) begin
          data_data_ok = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign io.inst_addr_ok = inst_addr_ok;
  assign io.data_addr_ok = data_addr_ok;
  assign io.inst_data_ok = inst_data_ok;
  assign io.data_data_ok = data_data_ok;
  assign io.inst_rdata   = io.rdata;
  assign io.data_rdata   = io.rdata;
  assign io.req          = req;
  assign io.wr           = wr_q;
  assign io.size         = size_q;
  assign io.addr         = addr_q;
  assign io.wdata        = wdata_q;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: each task drives one scenario cycle by
// cycle and checks bus and master outputs against hand-derived values.
module tb_sram_like_arbiter;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   failures = 0;

  sram_like_arbiter_if io();

  sram_like_arbiter dut (
    .clk    (clk),
    .resetn (resetn),
    .io     (io)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs change here, checks at +1.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    io.inst_req = 1'b0; io.inst_addr = 32'd0;
    io.data_req = 1'b0; io.data_wr = 1'b0; io.data_size = 2'd0;
    io.data_addr = 32'd0; io.data_wdata = 32'd0;
    io.addr_ok = 1'b0; io.data_ok = 1'b0; io.rdata = 32'd0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    clear_inputs();
    io.inst_req = 1'b1; io.inst_addr = 32'h1234_5678;
    io.data_req = 1'b1; io.data_wr = 1'b1; io.data_size = 2'd2;
    io.data_addr = 32'hDEAD_BEEF; io.data_wdata = 32'hCAFE_F00D;
    io.data_ok = 1'b1;
    #2;
    tick();
    #1;
    checks++; if (io.req !== 1'b0 || io.wr !== 1'b0 || io.size !== 2'd0) begin failures++; $display("FAIL rst_ctrl req=%0b wr=%0b size=%0d exp 0/0/0", io.req, io.wr, io.size); end
    checks++; if (io.addr !== 32'd0 || io.wdata !== 32'd0) begin failures++; $display("FAIL rst_bus addr=%h wdata=%h exp 0/0", io.addr, io.wdata); end
    checks++; if (io.inst_addr_ok !== 1'b0 || io.data_addr_ok !== 1'b0) begin failures++; $display("FAIL rst_addr_ok inst=%0b data=%0b exp 0/0", io.inst_addr_ok, io.data_addr_ok); end
    checks++; if (io.inst_data_ok !== 1'b0 || io.data_data_ok !== 1'b0) begin failures++; $display("FAIL rst_data_ok inst=%0b data=%0b exp 0/0", io.inst_data_ok, io.data_data_ok); end
    tick();
    io.data_ok = 1'b0;
    resetn = 1'b1;
  endtask

  // Both masters request straight out of reset, then contention alternates.
  task automatic test_priority();
    io.inst_addr = 32'hBFC0_0100;
    io.data_wr = 1'b0; io.data_size = 2'd2; io.data_addr = 32'h0000_1000; io.data_wdata = 32'd0;
    #1;
    checks++; if (io.data_addr_ok !== 1'b1 || io.inst_addr_ok !== 1'b0) begin failures++; $display("FAIL prio_first data=%0b inst=%0b exp 1/0", io.data_addr_ok, io.inst_addr_ok); end
    tick();
    io.addr_ok = 1'b1;
    #1;
    checks++; if (io.req !== 1'b1 || io.addr !== 32'h0000_1000 || io.inst_addr_ok !== 1'b0 || io.data_addr_ok !== 1'b0) begin failures++; $display("FAIL prio_daddr req=%0b addr=%h iok=%0b dok=%0b exp 1/00001000/0/0", io.req, io.addr, io.inst_addr_ok, io.data_addr_ok); end
    tick();
    io.addr_ok = 1'b0; io.data_ok = 1'b1; io.rdata = 32'h1122_3344;
    #1;
    checks++; if (io.data_data_ok !== 1'b1 || io.data_rdata !== 32'h1122_3344 || io.inst_data_ok !== 1'b0 || io.inst_addr_ok !== 1'b0) begin failures++; $display("FAIL prio_dwait ddok=%0b rdata=%h idok=%0b iaok=%0b exp 1/11223344/0/0", io.data_data_ok, io.data_rdata, io.inst_data_ok, io.inst_addr_ok); end
    tick();
    io.data_ok = 1'b0;
    #1;
    checks++; if (io.inst_addr_ok !== 1'b1 || io.data_addr_ok !== 1'b0 || io.req !== 1'b0) begin failures++; $display("FAIL prio_second inst=%0b data=%0b req=%0b exp 1/0/0", io.inst_addr_ok, io.data_addr_ok, io.req); end
    tick();
    io.addr_ok = 1'b1; io.data_ok = 1'b1; io.rdata = 32'h2408_0005;
    #1;
    checks++; if (io.addr !== 32'hBFC0_0100 || io.wr !== 1'b0 || io.size !== 2'd2 || io.wdata !== 32'd0) begin failures++; $display("FAIL prio_ibus addr=%h wr=%0b size=%0d wdata=%h exp bfc00100/0/2/0", io.addr, io.wr, io.size, io.wdata); end
    checks++; if (io.inst_data_ok !== 1'b1 || io.inst_rdata !== 32'h2408_0005) begin failures++; $display("FAIL prio_idone idok=%0b rdata=%h exp 1/24080005", io.inst_data_ok, io.inst_rdata); end
    tick();
    io.addr_ok = 1'b0; io.data_ok = 1'b0;
    #1;
    checks++; if (io.data_addr_ok !== 1'b1 || io.inst_addr_ok !== 1'b0) begin failures++; $display("FAIL prio_third data=%0b inst=%0b exp 1/0", io.data_addr_ok, io.inst_addr_ok); end
    tick();
    io.inst_req = 1'b0; io.data_req = 1'b0;
    io.addr_ok = 1'b1; io.data_ok = 1'b1;
    tick();
    clear_inputs();
  endtask

  task automatic test_inst_only();
    io.inst_req = 1'b1; io.inst_addr = 32'hBFC0_0000;
    #1;
    checks++; if (io.inst_addr_ok !== 1'b1 || io.data_addr_ok !== 1'b0 || io.req !== 1'b0) begin failures++; $display("FAIL inst_c0 iaok=%0b daok=%0b req=%0b exp 1/0/0", io.inst_addr_ok, io.data_addr_ok, io.req); end
    tick();
    io.inst_req = 1'b0; io.inst_addr = 32'h0;
    #1;
    checks++; if (io.req !== 1'b1 || io.addr !== 32'hBFC0_0000 || io.wr !== 1'b0 || io.size !== 2'd2 || io.wdata !== 32'd0) begin failures++; $display("FAIL inst_c1 req=%0b addr=%h wr=%0b size=%0d wdata=%h exp 1/bfc00000/0/2/0", io.req, io.addr, io.wr, io.size, io.wdata); end
    tick();
    io.addr_ok = 1'b1;
    #1;
    checks++; if (io.req !== 1'b1 || io.inst_data_ok !== 1'b0) begin failures++; $display("FAIL inst_c2 req=%0b idok=%0b exp 1/0", io.req, io.inst_data_ok); end
    tick();
    io.addr_ok = 1'b0;
    #1;
    checks++; if (io.req !== 1'b0 || io.inst_data_ok !== 1'b0) begin failures++; $display("FAIL inst_c3 req=%0b idok=%0b exp 0/0", io.req, io.inst_data_ok); end
    tick();
    io.data_ok = 1'b1; io.rdata = 32'h3C08_0001;
    #1;
    checks++; if (io.inst_data_ok !== 1'b1 || io.inst_rdata !== 32'h3C08_0001 || io.data_data_ok !== 1'b0) begin failures++; $display("FAIL inst_c4 idok=%0b rdata=%h ddok=%0b exp 1/3c080001/0", io.inst_data_ok, io.inst_rdata, io.data_data_ok); end
    tick();
    io.data_ok = 1'b0;
    #1;
    checks++; if (io.inst_data_ok !== 1'b0 || io.req !== 1'b0) begin failures++; $display("FAIL inst_c5 idok=%0b req=%0b exp 0/0", io.inst_data_ok, io.req); end
  endtask

  task automatic test_store();
    io.data_req = 1'b1; io.data_wr = 1'b1; io.data_size = 2'd0;
    io.data_addr = 32'h8000_0003; io.data_wdata = 32'h0000_00AB;
    #1;
    checks++; if (io.data_addr_ok !== 1'b1 || io.inst_addr_ok !== 1'b0) begin failures++; $display("FAIL store_acc daok=%0b iaok=%0b exp 1/0", io.data_addr_ok, io.inst_addr_ok); end
    tick();
    io.data_req = 1'b0; io.data_wr = 1'b0; io.data_size = 2'd2;
    io.data_addr = 32'h5555_5555; io.data_wdata = 32'hFFFF_FFFF;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) io.addr_ok = 1'b1;
      #1;
      checks++; if (io.req !== 1'b1 || io.wr !== 1'b1 || io.size !== 2'd0 || io.addr !== 32'h8000_0003 || io.wdata !== 32'h0000_00AB) begin failures++; $display("FAIL store_hold%0d req=%0b wr=%0b size=%0d addr=%h wdata=%h exp 1/1/0/80000003/000000ab", c, io.req, io.wr, io.size, io.addr, io.wdata); end
      tick();
    end
    io.addr_ok = 1'b0;
    #1;
    checks++; if (io.req !== 1'b0 || io.data_data_ok !== 1'b0) begin failures++; $display("FAIL store_wait req=%0b ddok=%0b exp 0/0", io.req, io.data_data_ok); end
    tick();
    io.data_ok = 1'b1;
    #1;
    checks++; if (io.data_data_ok !== 1'b1 || io.inst_data_ok !== 1'b0) begin failures++; $display("FAIL store_done ddok=%0b idok=%0b exp 1/0", io.data_data_ok, io.inst_data_ok); end
    tick();
    clear_inputs();
  endtask

  task automatic test_same_cycle();
    io.data_req = 1'b1; io.data_addr = 32'h0000_2000; io.data_size = 2'd1;
    tick();
    io.data_req = 1'b0;
    io.addr_ok = 1'b1; io.data_ok = 1'b1; io.rdata = 32'h0000_BEEF;
    #1;
    checks++; if (io.data_data_ok !== 1'b1 || io.data_rdata !== 32'h0000_BEEF || io.size !== 2'd1) begin failures++; $display("FAIL same_done ddok=%0b rdata=%h size=%0d exp 1/0000beef/1", io.data_data_ok, io.data_rdata, io.size); end
    tick();
    io.addr_ok = 1'b0; io.data_ok = 1'b0;
    io.inst_req = 1'b1; io.inst_addr = 32'hBFC0_0004;
    #1;
    checks++; if (io.inst_addr_ok !== 1'b1 || io.req !== 1'b0 || io.data_data_ok !== 1'b0) begin failures++; $display("FAIL same_idle iaok=%0b req=%0b ddok=%0b exp 1/0/0", io.inst_addr_ok, io.req, io.data_data_ok); end
    tick();
    io.inst_req = 1'b0;
    io.addr_ok = 1'b1; io.data_ok = 1'b1;
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    io.inst_req = 1'b1; io.inst_addr = 32'hBFC0_0008;
    tick();
    io.inst_req = 1'b0; io.addr_ok = 1'b1;
    tick();
    io.addr_ok = 1'b0;
    resetn = 1'b0;
    #1;
    checks++; if (io.req !== 1'b0 || io.addr !== 32'd0 || io.size !== 2'd0) begin failures++; $display("FAIL rmid_asserted req=%0b addr=%h size=%0d exp 0/0/0", io.req, io.addr, io.size); end
    tick();
    resetn = 1'b1;
    io.data_ok = 1'b1; io.rdata = 32'h0BAD_0BAD;
    #1;
    checks++; if (io.inst_data_ok !== 1'b0 || io.data_data_ok !== 1'b0) begin failures++; $display("FAIL rmid_dataok idok=%0b ddok=%0b exp 0/0", io.inst_data_ok, io.data_data_ok); end
    tick();
    io.data_ok = 1'b0;
    io.inst_req = 1'b1; io.data_req = 1'b1; io.data_addr = 32'h0000_3000;
    #1;
    checks++; if (io.data_addr_ok !== 1'b1 || io.inst_addr_ok !== 1'b0) begin failures++; $display("FAIL rmid_idle daok=%0b iaok=%0b exp 1/0", io.data_addr_ok, io.inst_addr_ok); end
    tick();
    io.inst_req = 1'b0; io.data_req = 1'b0;
    io.addr_ok = 1'b1; io.data_ok = 1'b1;
    tick();
    clear_inputs();
  endtask

  task automatic test_stray_data_ok();
    io.data_ok = 1'b1; io.rdata = 32'h7777_7777;
    #1;
    checks++; if (io.inst_data_ok !== 1'b0 || io.data_data_ok !== 1'b0 || io.req !== 1'b0) begin failures++; $display("FAIL stray_c0 idok=%0b ddok=%0b req=%0b exp 0/0/0", io.inst_data_ok, io.data_data_ok, io.req); end
    tick();
    io.data_ok = 1'b0;
    io.inst_req = 1'b1; io.inst_addr = 32'hBFC0_000C;
    #1;
    checks++; if (io.inst_addr_ok !== 1'b1 || io.req !== 1'b0) begin failures++; $display("FAIL stray_idle iaok=%0b req=%0b exp 1/0", io.inst_addr_ok, io.req); end
    tick();
    io.inst_req = 1'b0;
    io.addr_ok = 1'b1; io.data_ok = 1'b1;
    tick();
    clear_inputs();
  endtask

  // An inst request withdrawn while the bus is busy must never reach the bus.
  task automatic test_dropped_req();
    io.data_req = 1'b1; io.data_addr = 32'h0000_4000;
    tick();
    io.data_req = 1'b0;
    io.inst_req = 1'b1; io.inst_addr = 32'hBFC0_0010;
    #1;
    checks++; if (io.inst_addr_ok !== 1'b0 || io.addr !== 32'h0000_4000) begin failures++; $display("FAIL drop_busy iaok=%0b addr=%h exp 0/00004000", io.inst_addr_ok, io.addr); end
    tick();
    io.inst_req = 1'b0;
    io.addr_ok = 1'b1; io.data_ok = 1'b1;
    tick();
    io.addr_ok = 1'b0; io.data_ok = 1'b0;
    tick();
    #1;
    checks++; if (io.req !== 1'b0 || io.inst_data_ok !== 1'b0 || io.addr !== 32'h0000_4000) begin failures++; $display("FAIL drop_never req=%0b idok=%0b addr=%h exp 0/0/00004000", io.req, io.inst_data_ok, io.addr); end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_inst_only();
    tick();
    test_store();
    test_same_cycle();
    test_reset_mid();
    test_stray_data_ok();
    test_dropped_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 inst_req  input  1  instruction-side read request.
REQ-005 inst_addr  input  32  instruction fetch address.
REQ-006 inst_addr_ok  output  1  instruction request accepted this cycle.
REQ-007 inst_rdata  output  32  instruction read data.
REQ-008 inst_data_ok  output  1  instruction read data valid this cycle.
REQ-009 data_req  input  1  data-side request.
REQ-010 data_wr  input  1  1 = store, 0 = load.
REQ-011 data_size  input  2  0 = byte, 1 = half, 2 = word.
REQ-012 data_addr  input  32  data address.
REQ-013 data_wdata  input  32  store data.
REQ-014 data_addr_ok  output  1  data request accepted this cycle.
REQ-015 data_rdata  output  32  load data.
REQ-016 data_data_ok  output  1  data transaction complete this cycle.
REQ-017 req  output  1  bus request.
REQ-018 wr  output  1  bus write flag.
REQ-019 size  output  2  bus transfer size.
REQ-020 addr  output  32  bus address.
REQ-021 wdata  output  32  bus write data.
REQ-022 addr_ok  input  1  bus accepted the request.
REQ-023 rdata  input  32  bus read data.
REQ-024 data_ok  input  1  bus transaction complete.

Function
REQ-025 The block SHALL implement an FSM with states IDLE, I_ADDR, I_WAIT, D_ADDR and D_WAIT, and SHALL hold at most one bus transaction outstanding.
REQ-026 Grant in IDLE SHALL follow these rules: only data_req -> data; only inst_req -> inst; both -> data, unless the last grant was data, in which case inst wins.
REQ-027 Master acceptance SHALL be combinational: inst_addr_ok/data_addr_ok = 1 only in IDLE for the granted master, for one cycle; no master receives addr_ok in any other state.
REQ-028 On acceptance, the block SHALL register wr/size/addr/wdata and go to I_ADDR or D_ADDR; the instruction side SHALL be registered as wr=0, size=2, wdata=0.
REQ-029 req SHALL be 1 exactly in I_ADDR/D_ADDR; wr/size/addr/wdata SHALL stay constant while req=1.
REQ-030 In *_ADDR with addr_ok=1, the FSM SHALL move to *_WAIT; if data_ok=1 in the same cycle, it SHALL complete directly to IDLE.
REQ-031 In *_WAIT with data_ok=1, the FSM SHALL pulse the granted master's *_data_ok for one cycle and return to IDLE.
REQ-032 inst_rdata and data_rdata SHALL both equal rdata combinationally; only the *_data_ok outputs are gated.
REQ-033 A bus data_ok in IDLE SHALL be ignored: no master data_ok and no state change.
REQ-034 Minimum latency SHALL be: master accept cycle N; bus req at cycle N+1; master data_ok in the cycle the bus data_ok arrives; next accept no earlier than the following cycle.
REQ-035 Masters holding req while not accepted SHALL see no side effects; an inst_req dropped before acceptance is never issued.

Reset
REQ-036 While resetn=0, state SHALL be IDLE, the last-grant flag SHALL be inst, req=0, wr=0, size=0, addr=0, wdata=0, and all *_addr_ok and *_data_ok outputs SHALL be 0.
REQ-037 Reset asserted mid-transaction SHALL abandon the outstanding transaction; no master data_ok is produced for it after release.

Structure
REQ-038 The FSM state encoding and the size constants (SIZE_B=0, SIZE_H=1, SIZE_W=2) SHALL live in the shared package mips_bus_pkg.
REQ-039 The block SHALL be a single module with no sub-module.

Verification
REQ-040 Inst only: inst_req=1, addr=0xBFC00000; bus addr_ok at cycle 2, data_ok at cycle 4 with rdata=0x3C080001 -> inst_addr_ok at cycle 0, req at cycles 1-2, inst_data_ok and inst_rdata=0x3C080001 at cycle 4.
REQ-041 Both requesting from reset -> data granted first (data_addr_ok=1, inst_addr_ok=0); inst granted in the first IDLE cycle after data completes.
REQ-042 Store: data_wr=1, size=0, addr=0x80000003, wdata=0xAB -> bus wr=1, size=0, addr=0x80000003, wdata=0xAB held until addr_ok.
REQ-043 Same-cycle addr_ok and data_ok in D_ADDR -> data_data_ok in that cycle; IDLE next cycle.
REQ-044 resetn=0 in I_WAIT, bus data_ok after release -> inst_data_ok stays 0; state IDLE.
REQ-045 Stray data_ok=1 in IDLE -> both master data_ok outputs stay 0.
